// File: rtl/tx_8b10b_serializer.sv
// ---------------------------------------------------------------------------
// tx_8b10b_serializer
//
// Transmit end of the SERDES link. Bytes arrive over a valid/ready handshake,
// are 8b/10b encoded with running disparity (RD) and shifted out serially,
// one bit per clkTX, bit 9 (code bit 'a') first. After reset the block sends
// a preamble of SYNC_COMMAS+1 K28.5 commas (the reset word counts as the
// first one). Word slots that carry no data are filled with K28.5.
//
// Parameters
//   SYNC_COMMAS  K28.5 words loaded after the reset word before data is taken (>=1)
//
// Ports
//   clkTX      in   single clock, also forwarded to the receiver
//   resetN     in   asynchronous reset, active low
//   dataIn     in   [7:0] byte {HGF,EDCBA}: y = dataIn[7:5], x = dataIn[4:0]
//   kIn        in   1 = send dataIn as a control symbol (only K28.5 = 8'hBC legal)
//   dataValid  in   dataIn/kIn are valid
//   ready      out  byte is taken this cycle if dataValid = 1
//   SerialOut  out  serial line, MSB of the shift register
//   wordTick   out  1 on the last bit cycle of every word
//   syncing    out  1 while the sync preamble is being sent (FSM state view)
//   kErr       out  one-cycle pulse: an illegal K code was accepted
//
// Handshake: a byte is transferred on a rising clkTX edge where
// dataValid & ready are both 1. ready is only high during the last bit cycle
// of a word while in RUN; the source must hold dataValid/dataIn/kIn until it
// sees ready, nothing is buffered, and dataValid outside ready is ignored.
// ---------------------------------------------------------------------------
module tx_8b10b_serializer #(
    parameter int SYNC_COMMAS = 4
) (
    input  logic       clkTX,
    input  logic       resetN,
    input  logic [7:0] dataIn,
    input  logic       kIn,
    input  logic       dataValid,
    output logic       ready,
    output logic       SerialOut,
    output logic       wordTick,
    output logic       syncing,
    output logic       kErr
);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int              CNT_W     = (SYNC_COMMAS > 1) ? $clog2(SYNC_COMMAS) : 1;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_COMMAS - 1);

    // K28.5 in both disparity columns, abcdei_fghj with 'a' in bit 9.
    localparam logic [9:0] K285_NEG = 10'b001111_1010; // sent when RD-
    localparam logic [9:0] K285_POS = 10'b110000_0101; // sent when RD+
    localparam logic [7:0] K285_BYTE = 8'hBC;

    // -----------------------------------------------------------------------
    // Code tables. Each entry is {RD- form, RD+ form}; neutral codes carry
    // the same value twice, D.07 and D.x.3 carry their two balanced forms.
    // -----------------------------------------------------------------------
    function automatic logic [11:0] tbl_5b6b(input logic [4:0] x);
        logic [11:0] t;
        case (x)
            5'd0:  t = {6'b100111, 6'b011000};
            5'd1:  t = {6'b011101, 6'b100010};
            5'd2:  t = {6'b101101, 6'b010010};
            5'd3:  t = {6'b110001, 6'b110001};
            5'd4:  t = {6'b110101, 6'b001010};
            5'd5:  t = {6'b101001, 6'b101001};
            5'd6:  t = {6'b011001, 6'b011001};
            5'd7:  t = {6'b111000, 6'b000111};
            5'd8:  t = {6'b111001, 6'b000110};
            5'd9:  t = {6'b100101, 6'b100101};
            5'd10: t = {6'b010101, 6'b010101};
            5'd11: t = {6'b110100, 6'b110100};
            5'd12: t = {6'b001101, 6'b001101};
            5'd13: t = {6'b101100, 6'b101100};
            5'd14: t = {6'b011100, 6'b011100};
            5'd15: t = {6'b010111, 6'b101000};
            5'd16: t = {6'b011011, 6'b100100};
            5'd17: t = {6'b100011, 6'b100011};
            5'd18: t = {6'b010011, 6'b010011};
            5'd19: t = {6'b110010, 6'b110010};
            5'd20: t = {6'b001011, 6'b001011};
            5'd21: t = {6'b101010, 6'b101010};
            5'd22: t = {6'b011010, 6'b011010};
            5'd23: t = {6'b111010, 6'b000101};
            5'd24: t = {6'b110011, 6'b001100};
            5'd25: t = {6'b100110, 6'b100110};
            5'd26: t = {6'b010110, 6'b010110};
            5'd27: t = {6'b110110, 6'b001001};
            5'd28: t = {6'b001110, 6'b001110};
            5'd29: t = {6'b101110, 6'b010001};
            5'd30: t = {6'b011110, 6'b100001};
            5'd31: t = {6'b101011, 6'b010100};
            default: t = {6'b100111, 6'b011000};
        endcase
        return t;
    endfunction

    // use_alt selects the D.x.A7 form, which avoids a run of five equal bits
    // across the 6b/4b boundary.
    function automatic logic [7:0] tbl_3b4b(input logic [2:0] y, input logic use_alt);
        logic [7:0] t;
        case (y)
            3'd0: t = {4'b1011, 4'b0100};
            3'd1: t = {4'b1001, 4'b1001};
            3'd2: t = {4'b0101, 4'b0101};
            3'd3: t = {4'b1100, 4'b0011};
            3'd4: t = {4'b1101, 4'b0010};
            3'd5: t = {4'b1010, 4'b1010};
            3'd6: t = {4'b0110, 4'b0110};
            3'd7: t = use_alt ? {4'b0111, 4'b1000} : {4'b1110, 4'b0001};
            default: t = {4'b1011, 4'b0100};
        endcase
        return t;
    endfunction

    // A subblock flips RD when it is not balanced.
    function automatic logic unbal6(input logic [5:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) n++;
        end
        return (n != 3);
    endfunction

    function automatic logic unbal4(input logic [3:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) n++;
        end
        return (n != 2);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [9:0]       shreg_q,    shreg_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic             rd_q,       rd_d;     // RD after the word in shreg (1 = RD+)

    // -----------------------------------------------------------------------
    // Encoder: dataIn at the current rd_q.
    // -----------------------------------------------------------------------
    logic [4:0]  enc_x;
    logic [2:0]  enc_y;
    logic [11:0] enc_tbl6;
    logic [7:0]  enc_tbl4;
    logic [5:0]  enc_6b;
    logic [3:0]  enc_4b;
    logic        rd_mid;
    logic        use_alt;
    logic [9:0]  enc_word;
    logic        rd_enc;

    always_comb begin
        enc_x    = dataIn[4:0];
        enc_y    = dataIn[7:5];
        enc_tbl6 = tbl_5b6b(enc_x);
        enc_6b   = rd_q ? enc_tbl6[5:0] : enc_tbl6[11:6];
        rd_mid   = rd_q ^ unbal6(enc_6b);
        use_alt  = (!rd_mid && (enc_x == 5'd17 || enc_x == 5'd18 || enc_x == 5'd20)) ||
                   ( rd_mid && (enc_x == 5'd11 || enc_x == 5'd13 || enc_x == 5'd14));
        enc_tbl4 = tbl_3b4b(enc_y, use_alt);
        enc_4b   = rd_mid ? enc_tbl4[3:0] : enc_tbl4[7:4];
        rd_enc   = rd_mid ^ unbal4(enc_4b);
        enc_word = {enc_6b, enc_4b};
    end

    // -----------------------------------------------------------------------
    // FSM next state, datapath next state and outputs
    // -----------------------------------------------------------------------
    logic       take;
    logic       send_data;
    logic [9:0] comma_word;

    always_comb begin
        // defaults: mid-word shift
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        shreg_d    = {shreg_q[8:0], 1'b0};
        bit_cnt_d  = bit_cnt_q - 4'd1;
        rd_d       = rd_q;

        wordTick   = (bit_cnt_q == 4'd0);
        syncing    = (state_q == ST_SYNC);
        ready      = wordTick && (state_q == ST_RUN);
        take       = dataValid && ready;
        send_data  = take && !kIn;
        // Any accepted K request goes out as K28.5; only a wrong byte is flagged.
        kErr       = take && kIn && (dataIn != K285_BYTE);
        comma_word = rd_q ? K285_POS : K285_NEG;

        if (wordTick) begin
            bit_cnt_d = 4'd9;
            if (send_data) begin
                shreg_d = enc_word;
                rd_d    = rd_enc;
            end else begin
                shreg_d = comma_word;
                rd_d    = ~rd_q;
            end

            case (state_q)
                ST_SYNC: begin
                    if (sync_cnt_q == '0) state_d    = ST_RUN;
                    else                  sync_cnt_d = sync_cnt_q - CNT_W'(1);
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_SYNC;
            endcase
        end
    end

    assign SerialOut = shreg_q[9];

    // -----------------------------------------------------------------------
    // Registers. The reset word is the RD+ column of K28.5, so rd starts at RD-.
    // -----------------------------------------------------------------------
    always_ff @(posedge clkTX or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_SYNC;
            sync_cnt_q <= SYNC_LAST;
            shreg_q    <= K285_POS;
            bit_cnt_q  <= 4'd9;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            rd_q       <= rd_d;
        end
    end

endmodule
